// File: rtl/alu_accumulator_sequencer_if.sv
// Command, ALU-drive and status bundle between a command master and the accumulator sequencer.
interface alu_accumulator_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  cmdValid;
  logic                  cmdReady;
  logic [3:0]            cmdOp;
  logic                  cmdLoad;
  logic [DATA_WIDTH-1:0] cmdOperand;
  logic [DATA_WIDTH-1:0] aluA;
  logic [DATA_WIDTH-1:0] aluB;
  logic [3:0]            aluOp;
  logic [DATA_WIDTH-1:0] aluResult;
  logic                  aluZero;
  logic [DATA_WIDTH-1:0] acc;
  logic                  cmpFlag;
  logic                  zeroFlag;
  logic                  done;
  logic                  error;

  modport master (
    output cmdValid, cmdOp, cmdLoad, cmdOperand, aluResult, aluZero,
    input  cmdReady, aluA, aluB, aluOp, acc, cmpFlag, zeroFlag, done, error
  );

  modport slave (
    input  cmdValid, cmdOp, cmdLoad, cmdOperand, aluResult, aluZero,
    output cmdReady, aluA, aluB, aluOp, acc, cmpFlag, zeroFlag, done, error
  );
endinterface

// File: rtl/alu_accumulator_sequencer.sv
// Accumulator front end for the combinational ALU: IDLE -> EXEC -> RETIRE, done two cycles after acceptance.
// Accepts one command per 3 cycles; cmdReady is low in EXEC and RETIRE and nothing is queued.
module alu_accumulator_sequencer #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] ACC_INIT   = '0
) (
  input logic                    clk,
  input logic                    rst,
  alu_accumulator_sequencer_if.slave bus
);
  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_RESET = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_ADD   = 4'b0110;
  localparam logic [3:0] OP_SUB   = 4'b1000;
  localparam logic [3:0] OP_EQ    = 4'b1100;
  localparam logic [3:0] OP_GT    = 4'b1101;
  localparam logic [3:0] OP_LT    = 4'b1110;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_RETIRE = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  cmd_ready;
  logic [3:0]            alu_op;
  logic [3:0]            op_q;
  logic [DATA_WIDTH-1:0] operand_q;
  logic                  load_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic                  cmp_q;
  logic                  zero_q;
  logic                  done_q;
  logic                  err_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // The unused encoding falls through to the default and recovers to IDLE.
  always_comb begin
    state_nxt = S_IDLE;
    cmd_ready = 1'b0;
    alu_op    = OP_NOOP;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        state_nxt = bus.cmdValid ? S_EXEC : S_IDLE;
      end
      S_EXEC: begin
        alu_op    = op_q;
        state_nxt = S_RETIRE;
      end
      S_RETIRE: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= OP_NOOP;
      operand_q <= '0;
      load_q    <= 1'b0;
      acc_q     <= ACC_INIT;
      cmp_q     <= 1'b0;
      zero_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= (state == S_EXEC);
      if (state == S_IDLE && bus.cmdValid) begin
        op_q      <= bus.cmdOp;
        operand_q <= bus.cmdOperand;
        load_q    <= bus.cmdLoad;
      end
      if (state == S_EXEC) begin
        if (load_q) begin
          acc_q  <= operand_q;
          zero_q <= (operand_q == '0);
        end else begin
          case (op_q)
            OP_OR, OP_AND, OP_ADD, OP_SUB: begin
              acc_q  <= bus.aluResult;
              zero_q <= bus.aluZero;
            end
            OP_EQ, OP_GT, OP_LT: cmp_q <= bus.aluResult[0];
            OP_RESET: begin
              acc_q  <= ACC_INIT;
              zero_q <= (ACC_INIT == '0);
            end
            OP_NOOP: ;
            default: err_q <= 1'b1;
          endcase
        end
      end
    end
  end

  assign bus.cmdReady = cmd_ready;
  assign bus.aluA     = acc_q;
  assign bus.aluB     = operand_q;
  assign bus.aluOp    = alu_op;
  assign bus.acc      = acc_q;
  assign bus.cmpFlag  = cmp_q;
  assign bus.zeroFlag = zero_q;
  assign bus.done     = done_q;
  assign bus.error    = err_q;
endmodule

// File: tb/tb_alu_accumulator_sequencer.sv
// Bench for the accumulator sequencer with a behavioural 32-bit ALU closing the loop.
module tb_alu_accumulator_sequencer;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  alu_accumulator_sequencer_if #(.DATA_WIDTH(32)) bus ();

  alu_accumulator_sequencer #(.DATA_WIDTH(32), .ACC_INIT(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: unsigned compares return 0/1 in bit 0.
  logic [31:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (bus.aluOp)
      4'b0011: alu_res = bus.aluA | bus.aluB;
      4'b0101: alu_res = bus.aluA & bus.aluB;
      4'b0110: alu_res = bus.aluA + bus.aluB;
      4'b1000: alu_res = bus.aluA - bus.aluB;
      4'b1100: alu_res = {31'b0, bus.aluA == bus.aluB};
      4'b1101: alu_res = {31'b0, bus.aluA > bus.aluB};
      4'b1110: alu_res = {31'b0, bus.aluA < bus.aluB};
      default: alu_res = '0;
    endcase
  end
  assign bus.aluResult = alu_res;
  assign bus.aluZero   = (alu_res == 32'd0);

  typedef struct {
    logic [31:0] acc;
    logic        cmp;
    logic        zero;
    logic        err;
  } exp_t;

  typedef struct {
    logic        ld;
    logic [3:0]  op;
    logic [31:0] opd;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic ld, input logic [3:0] op, input logic [31:0] opd, input exp_t e);
    int   cyc;
    bit   seen;
    exp_t q;
    @(negedge clk);
    chk("ready_idle", {31'b0, bus.cmdReady}, 32'd1);
    bus.cmdValid   = 1'b1;
    bus.cmdLoad    = ld;
    bus.cmdOp      = op;
    bus.cmdOperand = opd;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    bus.cmdValid = 1'b0;
    chk("ready_exec", {31'b0, bus.cmdReady}, 32'd0);
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 8) begin
      if (bus.done) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    q = sb.pop_front();
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles, required 2", cyc);
    end else begin
      chk("latency", cyc, 32'd2);
      chk("ready_retire", {31'b0, bus.cmdReady}, 32'd0);
      chk("acc", bus.acc, q.acc);
      chk("aluA", bus.aluA, q.acc);
      chk("cmpFlag", {31'b0, bus.cmpFlag}, {31'b0, q.cmp});
      chk("zeroFlag", {31'b0, bus.zeroFlag}, {31'b0, q.zero});
      chk("error", {31'b0, bus.error}, {31'b0, q.err});
      @(negedge clk);
      chk("done_pulse", {31'b0, bus.done}, 32'd0);
      chk("aluOp_idle", {28'b0, bus.aluOp}, 32'd0);
    end
  endtask

  initial begin
    bit d_seen;
    errors = 0;
    checks = 0;
    rst            = 1'b1;
    bus.cmdValid   = 1'b0;
    bus.cmdLoad    = 1'b0;
    bus.cmdOp      = 4'b0000;
    bus.cmdOperand = 32'd0;

    //          ld    op       operand        acc           cmp   zero  err
    vecs.push_back('{1'b1, 4'h0, 32'd5,         '{32'd12 - 32'd7, 1'b0, 1'b0, 1'b0}});
    vecs.push_back('{1'b0, 4'h6, 32'd7,         '{32'd12,         1'b0, 1'b0, 1'b0}});
    vecs.push_back('{1'b1, 4'h0, 32'd3,         '{32'd3,          1'b0, 1'b0, 1'b0}});
    vecs.push_back('{1'b0, 4'h8, 32'd5,         '{32'hFFFF_FFFE,  1'b0, 1'b0, 1'b0}});
    vecs.push_back('{1'b1, 4'h0, 32'd4,         '{32'd4,          1'b0, 1'b0, 1'b0}});
    vecs.push_back('{1'b0, 4'h8, 32'd4,         '{32'd0,          1'b0, 1'b1, 1'b0}});
    vecs.push_back('{1'b1, 4'h0, 32'd10,        '{32'd10,         1'b0, 1'b0, 1'b0}});
    vecs.push_back('{1'b0, 4'hE, 32'd20,        '{32'd10,         1'b1, 1'b0, 1'b0}});
    vecs.push_back('{1'b0, 4'hD, 32'd20,        '{32'd10,         1'b0, 1'b0, 1'b0}});
    vecs.push_back('{1'b0, 4'hC, 32'd10,        '{32'd10,         1'b1, 1'b0, 1'b0}});
    vecs.push_back('{1'b1, 4'h0, 32'hF0F0_F0F0, '{32'hF0F0_F0F0,  1'b1, 1'b0, 1'b0}});
    vecs.push_back('{1'b0, 4'h5, 32'h0FF0_0FF0, '{32'h00F0_00F0,  1'b1, 1'b0, 1'b0}});
    vecs.push_back('{1'b0, 4'h3, 32'h0000_000F, '{32'h00F0_00FF,  1'b1, 1'b0, 1'b0}});
    vecs.push_back('{1'b0, 4'h1, 32'h0000_1234, '{32'd0,          1'b1, 1'b1, 1'b0}});
    vecs.push_back('{1'b0, 4'h0, 32'd5,         '{32'd0,          1'b1, 1'b1, 1'b0}});
    vecs.push_back('{1'b1, 4'h0, 32'h20,        '{32'h20,         1'b1, 1'b0, 1'b0}});
    vecs.push_back('{1'b0, 4'hD, 32'hFFFF_FFFF, '{32'h20,         1'b0, 1'b0, 1'b0}});
    vecs.push_back('{1'b0, 4'hF, 32'd3,         '{32'h20,         1'b0, 1'b0, 1'b1}});
    vecs.push_back('{1'b0, 4'h7, 32'd3,         '{32'h20,         1'b0, 1'b0, 1'b1}});
    vecs.push_back('{1'b0, 4'h6, 32'd1,         '{32'h21,         1'b0, 1'b0, 1'b1}});
    vecs.push_back('{1'b1, 4'hF, 32'd0,         '{32'd0,          1'b0, 1'b1, 1'b1}});

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {31'b0, bus.cmdReady}, 32'd1);
    chk("rst_acc", bus.acc, 32'd0);
    chk("rst_aluA", bus.aluA, 32'd0);
    chk("rst_aluB", bus.aluB, 32'd0);
    chk("rst_aluOp", {28'b0, bus.aluOp}, 32'd0);
    chk("rst_cmp", {31'b0, bus.cmpFlag}, 32'd0);
    chk("rst_zero", {31'b0, bus.zeroFlag}, 32'd1);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_error", {31'b0, bus.error}, 32'd0);

    for (int i = 0; i < vecs.size(); i++)
      send(vecs[i].ld, vecs[i].op, vecs[i].opd, vecs[i].e);

    // Reset in the EXEC cycle of ADD 9 must drop the command.
    send(1'b1, 4'h0, 32'd1, '{32'd1, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    bus.cmdValid   = 1'b1;
    bus.cmdLoad    = 1'b0;
    bus.cmdOp      = 4'h6;
    bus.cmdOperand = 32'd9;
    @(posedge clk);
    @(negedge clk);
    bus.cmdValid = 1'b0;
    chk("exec_aluOp", {28'b0, bus.aluOp}, 32'h6);
    chk("exec_aluA", bus.aluA, 32'd1);
    chk("exec_aluB", bus.aluB, 32'd9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_done", {31'b0, bus.done}, 32'd0);
    chk("mid_rst_acc", bus.acc, 32'd0);
    chk("mid_rst_ready", {31'b0, bus.cmdReady}, 32'd1);
    chk("mid_rst_error", {31'b0, bus.error}, 32'd0);
    chk("mid_rst_zero", {31'b0, bus.zeroFlag}, 32'd1);
    chk("mid_rst_aluB", bus.aluB, 32'd0);
    d_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      d_seen = d_seen | bus.done;
    end
    chk("mid_rst_no_done", {31'b0, d_seen}, 32'd0);

    // cmdValid held through EXEC/RETIRE: second command only taken back in IDLE.
    @(negedge clk);
    bus.cmdValid   = 1'b1;
    bus.cmdLoad    = 1'b1;
    bus.cmdOp      = 4'h0;
    bus.cmdOperand = 32'd7;
    @(posedge clk);
    @(negedge clk);
    bus.cmdLoad    = 1'b0;
    bus.cmdOp      = 4'h6;
    bus.cmdOperand = 32'd2;
    chk("hold_ready_exec", {31'b0, bus.cmdReady}, 32'd0);
    @(negedge clk);
    chk("hold_done1", {31'b0, bus.done}, 32'd1);
    chk("hold_acc1", bus.acc, 32'd7);
    chk("hold_ready_retire", {31'b0, bus.cmdReady}, 32'd0);
    @(negedge clk);
    chk("hold_ready_idle", {31'b0, bus.cmdReady}, 32'd1);
    chk("hold_aluOp_idle", {28'b0, bus.aluOp}, 32'd0);
    chk("hold_done_low", {31'b0, bus.done}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.cmdValid = 1'b0;
    chk("hold_aluOp_exec", {28'b0, bus.aluOp}, 32'h6);
    @(negedge clk);
    chk("hold_done2", {31'b0, bus.done}, 32'd1);
    chk("hold_acc2", bus.acc, 32'd9);
    repeat (3) @(negedge clk);
    chk("hold_acc_final", bus.acc, 32'd9);
    chk("hold_done_final", {31'b0, bus.done}, 32'd0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_accumulator_sequencer.md
Name: alu_accumulator_sequencer

Overview:
Sequential front end for the 32-bit combinational ALU. It accepts commands over a valid/ready handshake and holds an accumulator. It drives the ALU operand and opcode inputs from the accumulator and the latched command operand, captures the ALU result and zero flag on the next clock, and writes the result back to the accumulator or to a compare flag. It sits directly upstream of the ALU and also consumes the ALU's result.

Parameters:
DATA_WIDTH, 32, datapath width; only 32 is supported, matching the ALU.
ACC_INIT, 32'h0000_0000, accumulator value after reset and after the RESET opcode.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
cmdValid  input  1  command present.
cmdReady  output  1  sequencer can accept a command.
cmdOp  input  4  opcode, same encoding as the ALU: 0000 NOOP, 0001 RESET, 0011 OR, 0101 AND, 0110 ADD, 1000 SUB, 1100 EQUAL, 1101 GREATER_THAN, 1110 LESS_THAN, 1111 ERROR.
cmdLoad  input  1  load cmdOperand into the accumulator; cmdOp is ignored.
cmdOperand  input  32  b operand.
aluA  output  32  to ALU a; equals acc.
aluB  output  32  to ALU b; the latched operand.
aluOp  output  4  to ALU opCode; the latched opcode during EXEC, 0000 otherwise.
aluResult  input  32  from ALU result.
aluZero  input  1  from ALU zero.
acc  output  32  accumulator.
cmpFlag  output  1  result of the last compare op.
zeroFlag  output  1  zero status of the last accumulator write.
done  output  1  one-cycle pulse when a command retires.
error  output  1  sticky error flag.

Behaviour:
- Reset (rst=1 at a clock edge, any state, including mid-command):
  - state goes to IDLE; the in-flight command is dropped with no write and no done.
  - acc=ACC_INIT, cmpFlag=0, zeroFlag=1, done=0, error=0, cmdReady=1 in the following cycle, latched op=0000, latched operand=0.
- States: IDLE, EXEC, RETIRE. Encoding is free; no illegal state may lock up, and any unreachable state goes to IDLE.
- IDLE:
  - cmdReady=1.
  - On cmdValid&cmdReady, latch cmdOp, cmdOperand and cmdLoad, then go to EXEC.
  - Otherwise stay in IDLE.
- EXEC: lasts one cycle; cmdReady=0; aluOp=latched op. At the end-of-cycle edge, act by the latched command:
  - cmdLoad=1: acc<=operand; zeroFlag<=(operand==0).
  - OR, AND, ADD, SUB: acc<=aluResult; zeroFlag<=aluZero. ADD and SUB wrap modulo 2^32 with no carry or overflow reported. SUB computes acc-operand.
  - EQUAL, GREATER_THAN, LESS_THAN: cmpFlag<=aluResult[0]; acc and zeroFlag are unchanged. Compares are unsigned: GREATER_THAN means acc>operand, LESS_THAN means acc<operand.
  - RESET: acc<=ACC_INIT; zeroFlag<=(ACC_INIT==0); error is not cleared.
  - NOOP: no state change.
  - ERROR (1111) or any unlisted code (0010, 0100, 0111, 1001, 1010, 1011): error<=1; acc, cmpFlag and zeroFlag are unchanged.
  - Then go to RETIRE.
- RETIRE: done=1 for exactly this cycle; cmdReady=0; return to IDLE.
- Timing:
  - Latency from acceptance edge to done high is 2 cycles; the updated acc is visible in the same cycle as done.
  - Maximum throughput is 1 command per 3 cycles.
- Handshake:
  - Holding cmdValid high while cmdReady is low has no effect, and the command is not queued.
  - The master holds cmdOp and cmdOperand stable until acceptance.
- aluA always equals acc, including outside EXEC. Outside EXEC, aluB holds the last latched operand and aluOp=0000.
- error is cleared only by rst.
- All outputs are registered, except aluA (=acc, itself a register), aluOp and cmdReady, which are decoded from state and latches.

Test Plan:
1. After rst, accept LOAD 5, then ADD 7 -> done high 2 cycles after each acceptance; acc=12, zeroFlag=0, cmdReady low for exactly 2 cycles per command.
2. With acc=3, SUB 5 -> acc=32'hFFFF_FFFE, zeroFlag=0. Then LOAD 4, SUB 4 -> acc=0, zeroFlag=1.
3. With acc=10:
   - LESS_THAN 20 -> cmpFlag=1, acc remains 10.
   - GREATER_THAN 20 -> cmpFlag=0.
   - EQUAL 10 -> cmpFlag=1.
4. With acc=32'hF0F0_F0F0:
   - AND 32'h0FF0_0FF0 -> acc=32'h00F0_00F0.
   - Then OR 32'h0000_000F -> acc=32'h00F0_00FF.
   - Then RESET -> acc=0, zeroFlag=1.
5. Send opcode 1111, then 0111, then ADD 1 -> error rises at the first retire and stays 1. acc is unchanged by both error ops, and the ADD still executes (acc+1).
6. Assert rst during EXEC of ADD 9 with acc=1 -> no done pulse; next cycle acc=ACC_INIT, cmdReady=1, error=0. Also check cmdValid held high while in RETIRE is not accepted until IDLE.
